hazard_ctrl: RTL

//  Scoreboard-based stall/forwarding controller for the 5-stage pipeline. Tracks in-flight GRF writes
//  (E/M/W destination, Tnew) and the multi-cycle mult/div unit. Drives the stall/bubble controls and
//  the forwarding-mux selects for the D, E and M stages. The GRF writes on negedge, so W->D needs no bypass.

---
 rtl/hazard_ctrl_pkg.sv | 26 ++
 rtl/hazard_ctrl_stage_rec.sv | 41 ++++
 rtl/hazard_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
// The forwarding codes here are the same ones the datapath muxes decode.
//   FWD_GRF/FWD_E/FWD_M/FWD_W : forwarding-mux select encodings
//   TUSE_NONE                  : Tuse value for an operand that is never read
//   hc_rec_t                   : one in-flight GRF-write record (dst, tnew, md flags)
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_GRF   = 2'd0;
    localparam logic [1:0] FWD_E     = 2'd1;
    localparam logic [1:0] FWD_M     = 2'd2;
    localparam logic [1:0] FWD_W     = 2'd3;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    typedef struct packed {
        logic [4:0] dst;     // 0 = slot does not write the GRF
        logic [1:0] tnew;    // cycles until the result exists
        logic       md;      // slot holds a mult/div start
        logic       md_div;  // qualifies md: 1 = div, 0 = mult
    } hc_rec_t;

    // True when a slot writes reg s and the value is ready to bypass.
    function automatic logic rec_ready(input hc_rec_t r, input logic [4:0] s);
        return (r.dst != 5'd0) && (r.dst == s) && (r.tnew == 2'd0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_stage_rec.sv
// One pipeline record of the hazard scoreboard.
//   clk, reset : clock, synchronous active-high reset (clears the record)
//   rec_in     : record from the previous stage
//   bubble     : load an all-zero record instead of rec_in
//   dec        : decrement tnew while passing (saturating at 0)
//   rec_out    : registered record
module hc_stage_rec
    import hazard_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  hc_rec_t rec_in,
    input  logic    bubble,
    input  logic    dec,
    output hc_rec_t rec_out
);

    hc_rec_t rec_d;
    hc_rec_t rec_q;

    always_comb begin
        rec_d = rec_in;
        if (dec && (rec_in.tnew != 2'd0)) begin
            rec_d.tnew = rec_in.tnew - 2'd1;
        end
        if (bubble) begin
            rec_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q <= '0;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rec_out = rec_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Scoreboard-based stall/forwarding controller for the 5-stage pipeline.
// Tracks E/M/W GRF writes and the multi-cycle mult/div unit.
//   clk, reset          : clock, synchronous active-high reset
//   D_*                 : operand/dest/Tuse/Tnew/md info of the instruction in D
//   E_rs, E_rt, M_rt    : operand addresses read in E and M
//   stall               : freeze PC and F/D, bubble into E
//   fwd_D_rs/rt         : GRF / E / M
//   fwd_E_rs/rt         : pipe reg / M / W
//   fwd_M_rt            : pipe reg / W
//   md_busy             : mult/div counter nonzero
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs,
    input  logic [4:0] D_rt,
    input  logic [1:0] D_tuse_rs,
    input  logic [1:0] D_tuse_rt,
    input  logic [4:0] D_dst,
    input  logic [1:0] D_tnew,
    input  logic       D_md_start,
    input  logic       D_md_div,
    input  logic       D_md_use,
    input  logic [4:0] E_rs,
    input  logic [4:0] E_rt,
    input  logic [4:0] M_rt,
    output logic       stall,
    output logic [1:0] fwd_D_rs,
    output logic [1:0] fwd_D_rt,
    output logic [1:0] fwd_E_rs,
    output logic [1:0] fwd_E_rt,
    output logic       fwd_M_rt,
    output logic       md_busy
);

    hc_rec_t d_rec, e_rec, m_rec, w_rec;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic grf_stall, md_stall;

    assign d_rec = '{dst: D_dst, tnew: D_tnew, md: D_md_start, md_div: D_md_div};

    hc_stage_rec u_rec_e (.clk(clk), .reset(reset), .rec_in(d_rec), .bubble(stall),
                          .dec(1'b0), .rec_out(e_rec));
    hc_stage_rec u_rec_m (.clk(clk), .reset(reset), .rec_in(e_rec), .bubble(1'b0),
                          .dec(1'b1), .rec_out(m_rec));
    // W also decrements so a load (tnew 2 in E) arrives in W ready to bypass.
    hc_stage_rec u_rec_w (.clk(clk), .reset(reset), .rec_in(m_rec), .bubble(1'b0),
                          .dec(1'b1), .rec_out(w_rec));

    function automatic logic src_hazard(input logic [4:0] s, input logic [1:0] tuse,
                                        input hc_rec_t e, input hc_rec_t m);
        return (s != 5'd0) &&
               (((e.dst == s) && (e.tnew > tuse)) || ((m.dst == s) && (m.tnew > tuse)));
    endfunction

    always_comb begin
        grf_stall = src_hazard(D_rs, D_tuse_rs, e_rec, m_rec) ||
                    src_hazard(D_rt, D_tuse_rt, e_rec, m_rec);
        md_stall  = D_md_use && ((cnt_q != '0) || e_rec.md);
        stall     = grf_stall || md_stall;
    end

    // Counter loads while the start sits in E, so the E cycle plus the
    // countdown gives the full busy window seen by a waiting HI/LO user.
    always_comb begin
        cnt_d = cnt_q;
        if (e_rec.md) begin
            cnt_d = e_rec.md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign md_busy = (cnt_q != '0);

    always_comb begin
        fwd_D_rs = rec_ready(e_rec, D_rs) ? FWD_E : (rec_ready(m_rec, D_rs) ? FWD_M : FWD_GRF);
        fwd_D_rt = rec_ready(e_rec, D_rt) ? FWD_E : (rec_ready(m_rec, D_rt) ? FWD_M : FWD_GRF);
        fwd_E_rs = rec_ready(m_rec, E_rs) ? FWD_M : (rec_ready(w_rec, E_rs) ? FWD_W : FWD_GRF);
        fwd_E_rt = rec_ready(m_rec, E_rt) ? FWD_M : (rec_ready(w_rec, E_rt) ? FWD_W : FWD_GRF);
        fwd_M_rt = rec_ready(w_rec, M_rt);
    end

endmodule
